// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator and the SPI register bank.
package pwm_pkg;

  // Register map shared with the SPI block
  localparam int unsigned REG_ADDR_W = 3;
  localparam logic [REG_ADDR_W-1:0] REG_EN_OUT_LO = 3'd0;
  localparam logic [REG_ADDR_W-1:0] REG_EN_OUT_HI = 3'd1;
  localparam logic [REG_ADDR_W-1:0] REG_EN_PWM_LO = 3'd2;
  localparam logic [REG_ADDR_W-1:0] REG_EN_PWM_HI = 3'd3;
  localparam logic [REG_ADDR_W-1:0] REG_DUTY      = 3'd4;
  localparam logic [REG_ADDR_W-1:0] MAX_REG_ADDR  = REG_DUTY;

  // Datapath sizing
  localparam int unsigned REG_W   = 8;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned NUM_CH  = 16;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

  // Defaults: 10 MHz / (13 * 256) gives roughly a 3 kHz PWM period
  localparam int unsigned CLK_DIV_DEF = 13;
  localparam int unsigned CNT_W_DEF   = 8;

  // Control register image as seen by the generator
  typedef struct packed {
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [DUTY_W-1:0] duty;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to the PWM step rate; step_tick is high for one clk every CLK_DIV clks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic step_tick
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;

  // Tick decodes the terminal count so CLK_DIV=1 ticks every cycle
  assign step_tick = (pre_cnt == PRE_MAX);

  // Prescaler counts 0..CLK_DIV-1 and wraps on the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (step_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// 16-channel PWM generator driven by the SPI control registers.
// One shared step counter and duty compare; each channel is off, static high or PWM.
// Build option: define PWM_SYNC_UPDATE_EN to latch duty only at the period wrap,
// otherwise duty changes take effect on the next clk.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_out_lo,
  input  logic [7:0]  en_out_hi,
  input  logic [7:0]  en_pwm_lo,
  input  logic [7:0]  en_pwm_hi,
  input  logic [7:0]  duty,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pwm_cfg_t          cfg;
  logic              step_tick;
  logic [CNT_W-1:0]  step_cnt;
  logic              wrap;
  logic [DUTY_W-1:0] duty_act;
  logic              pwm_lvl;

  assign cfg = '{en_out: {en_out_hi, en_out_lo},
                 en_pwm: {en_pwm_hi, en_pwm_lo},
                 duty:   duty};

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .step_tick (step_tick)
  );

  // Period wraps on the step tick seen at the last step
  assign wrap = step_tick && (step_cnt == CNT_MAX);

  // Step counter advances once per prescaler tick, modulo 2**CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (step_tick) begin
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  // Pulse marks the first clk in which the counter sits at zero after a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  // Shadow duty: sampled at the wrap so the new value governs the whole new period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act <= '0;
    end else if (wrap) begin
      duty_act <= cfg.duty;
    end
  end
`else
  // Duty follows the register directly
  assign duty_act = cfg.duty;
`endif

  // Full-scale duty is forced high to avoid a one-step low glitch at step 255
  assign pwm_lvl = (duty_act == DUTY_FULL) ? 1'b1 : (step_cnt < CNT_W'(duty_act));

  // Per-channel mux: disabled -> 0, PWM mode -> shared level, otherwise static high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= cfg.en_out & (~cfg.en_pwm | {NUM_CH{pwm_lvl}});
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: a cycle-count reference model queues the expected
// outputs at every clk edge and a monitor pops and compares them on the falling edge.
module tb_pwm_gen;

  localparam int unsigned CLK_DIV = 13;
  localparam int unsigned STEPS   = 256;
  localparam int unsigned PERIOD  = CLK_DIV * STEPS;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [15:0] pwm_out;
  logic        period_start;

  pwm_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_out_lo    (en_out_lo),
    .en_out_hi    (en_out_hi),
    .en_pwm_lo    (en_pwm_lo),
    .en_pwm_hi    (en_pwm_hi),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pwm;
    logic        ps;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned mn       = 0;
  logic [7:0]  m_duty_act = 8'h00;
  int          cur_len  = 0;
  int          cur_high = 0;
  int          last_len = 0;
  int          last_high = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  // Reference model: output state is a function of clk edges elapsed since reset release
  always @(posedge clk) begin : model
    exp_t        e;
    int unsigned step_prev;
    logic [7:0]  da;
    logic        lvl;
    logic [15:0] eo;
    logic [15:0] ep;
    if (rst) begin
      mn = 0;
      m_duty_act = 8'h00;
      e.pwm = 16'h0000;
      e.ps  = 1'b0;
    end else begin
      mn++;
      step_prev = ((mn - 1) / CLK_DIV) % STEPS;
`ifdef PWM_SYNC_UPDATE_EN
      da = m_duty_act;
`else
      da = duty;
`endif
      lvl = (da == 8'hFF) ? 1'b1 : (step_prev < 32'(da));
      eo  = {en_out_hi, en_out_lo};
      ep  = {en_pwm_hi, en_pwm_lo};
      for (int i = 0; i < 16; i++) e.pwm[i] = eo[i] & (ep[i] ? lvl : 1'b1);
      e.ps = ((mn % PERIOD) == 0);
      if ((mn % PERIOD) == 0) m_duty_act = duty;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare every presented output against the queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() == 0) begin
      check("expect_queue_nonempty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("pwm_out", 32'(pwm_out), 32'(e.pwm));
      check("period_start", 32'(period_start), 32'(e.ps));
    end
    if (period_start) begin
      last_len  = cur_len;
      last_high = cur_high;
      cur_len   = 1;
      cur_high  = 32'(pwm_out[0]);
    end else begin
      cur_len++;
      cur_high += 32'(pwm_out[0]);
    end
  end

  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_out_lo = eo[7:0];
    en_out_hi = eo[15:8];
    en_pwm_lo = ep[7:0];
    en_pwm_hi = ep[15:8];
    duty      = d;
  endtask

  // Wait (bounded) for the next period_start; returns the number of clks waited
  task automatic wait_ps(input string name, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!period_start && waited < int'(PERIOD) + 20);
    check({name, "_seen"}, 32'(period_start), 32'd1);
  endtask

  initial begin : stim
    int w;
    int exp_h;

    // Reset held with all registers at 0xFF
    rst = 1'b1;
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    repeat (5) @(negedge clk);
    check("reset_pwm_out", 32'(pwm_out), 32'h0);
    #1 rst = 1'b0;
    wait_ps("t1_first_ps", w);
    check("t1_first_ps_delay", 32'(w), 32'(PERIOD));

    // Static-high lower byte
    set_regs(16'h00FF, 16'h0000, 8'h55);
    repeat (300) @(negedge clk);
    check("t2_static", 32'(pwm_out), 32'h00FF);

    // 50% duty on all channels
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    wait_ps("t3_ps_a", w);
    wait_ps("t3_ps_b", w);
    check("t3_period_len", 32'(last_len), 32'(PERIOD));
    check("t3_high_clks", 32'(last_high), 32'(128 * CLK_DIV));

    // Duty corners on ch0
    for (int k = 0; k < 3; k++) begin
      logic [7:0] d;
      d = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h01;
      exp_h = (k == 0) ? 0 : (k == 1) ? int'(PERIOD) : int'(CLK_DIV);
      set_regs(16'h0001, 16'h0001, d);
      wait_ps("t4_ps_a", w);
      wait_ps("t4_ps_b", w);
      check("t4_corner_high", 32'(last_high), 32'(exp_h));
      wait_ps("t4_ps_c", w);
      check("t4_corner_high_2", 32'(last_high), 32'(exp_h));
    end

    // Duty change 0x40 -> 0xC0 during the high phase
    set_regs(16'hFFFF, 16'hFFFF, 8'h40);
    wait_ps("t5_ps_a", w);
    wait_ps("t5_ps_b", w);
    repeat (30 * CLK_DIV) @(negedge clk);
    duty = 8'hC0;
    wait_ps("t5_ps_c", w);
`ifdef PWM_SYNC_UPDATE_EN
    check("t5_changed_period_high", 32'(last_high), 32'(64 * CLK_DIV));
`else
    check("t5_changed_period_high", 32'(last_high), 32'(192 * CLK_DIV));
`endif
    wait_ps("t5_ps_d", w);
    check("t5_next_period_high", 32'(last_high), 32'(192 * CLK_DIV));

    // Randomized register traffic checked cycle-by-cycle by the scoreboard
    for (int s = 0; s < 20; s++) begin
      set_regs(16'($urandom), 16'($urandom), 8'($urandom));
      repeat ($urandom_range(50, 1500)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a high phase
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    wait_ps("t6_ps_a", w);
    repeat (50 * CLK_DIV) @(negedge clk);
    check("t6_high_before_rst", 32'(pwm_out), 32'hFFFF);
    #1 rst = 1'b1;
    #1;
    check("t6_async_clear", 32'(pwm_out), 32'h0);
    check("t6_async_ps", 32'(period_start), 32'h0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    cur_len  = 0;
    cur_high = 0;
    wait_ps("t6_ps_b", w);
    check("t6_first_period_len", 32'(w), 32'(PERIOD));
`ifdef PWM_SYNC_UPDATE_EN
    check("t6_first_period_high", 32'(last_high), 32'd0);
`else
    check("t6_first_period_high", 32'(last_high), 32'(128 * CLK_DIV));
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
